// File: rtl/ama_riscv_mem_arb.sv
// -----------------------------------------------------------------------------
// ama_riscv_mem_arb
//
// Shares the single main-memory port between the I$ refill path and the D$
// refill/writeback path. One line-sized transaction is outstanding at a time:
// the winner's request is registered onto the memory port, and the memory
// response is routed back to whoever owns the transaction.
//
// D$ has priority because a D$ miss stalls the whole backend. When the
// MEM_ARB_STARVE_GUARD_EN macro is defined, a saturating counter tracks how
// long I$ has been refused while requesting; once it reaches STARVE_LIMIT, I$
// wins the next arbitration even if D$ is requesting. Without the macro the
// priority is strict and I$ may wait indefinitely.
//
// Handshake semantics (all request channels): a transfer happens in a cycle
// where valid and ready are both high at the rising clock edge. A requester
// holds valid and payload stable until it sees ready; the arbiter never
// withdraws ready once it has been presented with valid in the same cycle.
// The memory request channel follows the same rule, with the arbiter as the
// valid side. Response channels (*_rsp_valid, mem_rsp_valid) are single-cycle
// pulses with no back-pressure.
//
// Parameters:
//   ADDR_W        line address width (memory index, not byte address)
//   LINE_W        line data width in bits
//   STARVE_LIMIT  cycles I$ may lose arbitration while requesting (guard only)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ic_req_valid/ready/addr       I$ read request
//   ic_rsp_valid/data             I$ read data, one-cycle pulse
//   dc_req_valid/ready/addr/we/wdata  D$ refill (we=0) or writeback (we=1)
//   dc_rsp_valid/data             D$ read data or write ack, one-cycle pulse
//   mem_req_valid/ready/addr/we/wdata registered request to backing memory
//   mem_rsp_valid/data            memory response (also acks writes)
//   dbg_state                     current FSM state (IDLE=0, REQ=1, WAIT_RSP=2)
// -----------------------------------------------------------------------------
module ama_riscv_mem_arb #(
  parameter int ADDR_W       = 12,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,

  // I$ request / response
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_rsp_valid,
  output logic [LINE_W-1:0] ic_rsp_data,

  // D$ request / response
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_req_we,
  input  logic [LINE_W-1:0] dc_req_wdata,
  output logic              dc_rsp_valid,
  output logic [LINE_W-1:0] dc_rsp_data,

  // Backing memory port
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data,

  // Debug visibility of the FSM
  output logic [1:0]        dbg_state
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       owner;
  logic       grant_ic;
  logic       grant_dc;
  logic       starve_fire;
  logic       rsp_take;

  // ---------------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
  // Width covers 0..STARVE_LIMIT inclusive; a limit of 0 still needs one bit.
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  // Counts every cycle I$ is requesting but not being served, including the
  // cycles spent waiting while another transaction is in flight. Saturates so
  // the guard stays armed until I$ actually gets its handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (ic_req_valid && ic_req_ready) begin
      starve_cnt <= '0;
    end else if (ic_req_valid && !ic_req_ready && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  assign starve_fire = (starve_cnt == CNT_MAX);
`else
  // Strict D$ priority. STARVE_LIMIT is kept in the parameter list so both
  // builds share one instantiation; a non-negative limit never fires here.
  assign starve_fire = (STARVE_LIMIT < 0);
`endif

  // ---------------------------------------------------------------------------
  // Arbitration (combinational, only in IDLE)
  // ---------------------------------------------------------------------------
  // At most one grant can be high: I$ wins only when D$ is absent or the guard
  // has fired, and D$ is considered only when I$ did not win.
  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (state == IDLE) begin
      if (ic_req_valid && (starve_fire || !dc_req_valid)) begin
        grant_ic = 1'b1;
      end else if (dc_req_valid) begin
        grant_dc = 1'b1;
      end
    end
  end

  assign ic_req_ready = grant_ic;
  assign dc_req_ready = grant_dc;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // A response seen while still in REQ (even in the same cycle the memory
  // accepts) is ignored; the memory must answer at least one cycle later.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_ic || grant_dc) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, owner and registered memory request
  // ---------------------------------------------------------------------------
  // The payload registers load only on a handshake, so they stay stable for
  // the whole REQ stall and the memory sees a clean registered interface.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWNER_IC;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_we    <= 1'b0;
      mem_req_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant_dc) begin
        owner         <= OWNER_DC;
        mem_req_valid <= 1'b1;
        mem_req_addr  <= dc_req_addr;
        mem_req_we    <= dc_req_we;
        mem_req_wdata <= dc_req_wdata;
      end else if (grant_ic) begin
        // I$ only reads; write fields are forced to zero.
        owner         <= OWNER_IC;
        mem_req_valid <= 1'b1;
        mem_req_addr  <= ic_req_addr;
        mem_req_we    <= 1'b0;
        mem_req_wdata <= '0;
      end else if ((state == REQ) && mem_req_ready) begin
        mem_req_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing (combinational, no added latency)
  // ---------------------------------------------------------------------------
  assign rsp_take     = (state == WAIT_RSP) && mem_rsp_valid;
  assign ic_rsp_valid = rsp_take && (owner == OWNER_IC);
  assign dc_rsp_valid = rsp_take && (owner == OWNER_DC);

  // Data is broadcast; only the owner's valid qualifies it.
  assign ic_rsp_data  = mem_rsp_data;
  assign dc_rsp_data  = mem_rsp_data;

  assign dbg_state    = state;

endmodule

// File: tb/tb_ama_riscv_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_ama_riscv_mem_arb
//
// Requesters and the backing memory are driven from command queues and a
// small memory environment. A transaction-level reference model (who may be
// granted, whether a transaction is open/accepted, what data a read returns)
// pushes expected responses into queues at each handshake; a monitor pops and
// compares whenever the arbiter presents a response.
// Build with +define+MEM_ARB_STARVE_GUARD_EN to exercise the guarded variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ama_riscv_mem_arb;

  localparam int ADDR_W       = 12;
  localparam int LINE_W       = 128;
  localparam int STARVE_LIMIT = 8;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              ic_req_valid, ic_req_ready, ic_rsp_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic [LINE_W-1:0] ic_rsp_data;
  logic              dc_req_valid, dc_req_ready, dc_req_we, dc_rsp_valid;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [LINE_W-1:0] dc_req_wdata, dc_rsp_data;
  logic              mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata, mem_rsp_data;
  logic [1:0]        dbg_state;

  ama_riscv_mem_arb #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_we(dc_req_we), .dc_req_wdata(dc_req_wdata),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string name, input logic [LINE_W-1:0] act,
                           input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  function automatic logic [LINE_W-1:0] init_line(input logic [ADDR_W-1:0] a);
    return {4{8'hC3, 12'h000, a}};
  endfunction

  function automatic logic [LINE_W-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus command queues and drivers
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [LINE_W-1:0] wdata;
  } dc_cmd_t;

  logic [ADDR_W-1:0] ic_cmd_q[$];
  dc_cmd_t           dc_cmd_q[$];
  bit ic_hs_seen = 1'b0;
  bit dc_hs_seen = 1'b0;

  initial begin
    ic_req_valid = 1'b0; ic_req_addr = '0;
    dc_req_valid = 1'b0; dc_req_addr = '0; dc_req_we = 1'b0; dc_req_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (ic_hs_seen && ic_cmd_q.size() > 0) void'(ic_cmd_q.pop_front());
      if (dc_hs_seen && dc_cmd_q.size() > 0) void'(dc_cmd_q.pop_front());
      ic_hs_seen = 1'b0;
      dc_hs_seen = 1'b0;
      if (ic_cmd_q.size() > 0) begin
        ic_req_valid = 1'b1;
        ic_req_addr  = ic_cmd_q[0];
      end else begin
        ic_req_valid = 1'b0;
        ic_req_addr  = ADDR_W'($urandom());
      end
      if (dc_cmd_q.size() > 0) begin
        dc_req_valid = 1'b1;
        dc_req_addr  = dc_cmd_q[0].addr;
        dc_req_we    = dc_cmd_q[0].we;
        dc_req_wdata = dc_cmd_q[0].wdata;
      end else begin
        dc_req_valid = 1'b0;
        dc_req_addr  = ADDR_W'($urandom());
        dc_req_we    = 1'($urandom_range(1, 0));
        dc_req_wdata = rnd_line();
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Backing memory environment
  // ---------------------------------------------------------------------------
  logic [LINE_W-1:0] env_mem [logic [ADDR_W-1:0]];
  int env_ready_pct = 100;
  int env_delay_min = 0;
  int env_delay_max = 0;
  int env_stray_pct = 0;
  int env_stall_left = 0;
  bit env_pending = 1'b0;
  bit env_rsp_real = 1'b0;
  int env_delay = 0;
  logic [ADDR_W-1:0] env_addr;
  logic              env_we;
  bit                acc_seen = 1'b0;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [LINE_W-1:0] acc_wdata;

  initial begin
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    env_addr = '0; env_we = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (env_rsp_real) env_pending = 1'b0;
      env_rsp_real = 1'b0;
      if (acc_seen) begin
        acc_seen    = 1'b0;
        env_pending = 1'b1;
        env_addr    = acc_addr;
        env_we      = acc_we;
        if (acc_we) env_mem[acc_addr] = acc_wdata;
        env_delay = $urandom_range(env_delay_max, env_delay_min);
      end
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = rnd_line();
      if (env_pending) begin
        if (env_delay == 0) begin
          mem_rsp_valid = 1'b1;
          env_rsp_real  = 1'b1;
          if (!env_we) mem_rsp_data = env_mem.exists(env_addr) ? env_mem[env_addr]
                                                               : init_line(env_addr);
        end else begin
          env_delay--;
        end
      end else if ($urandom_range(99, 0) < env_stray_pct) begin
        mem_rsp_valid = 1'b1;
      end
      if (mem_req_valid && env_stall_left > 0) begin
        mem_req_ready = 1'b0;
        env_stall_left--;
      end else begin
        mem_req_ready = ($urandom_range(99, 0) < env_ready_pct);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model, scoreboard and monitor
  // ---------------------------------------------------------------------------
  logic [LINE_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  logic [LINE_W-1:0] ic_exp_q[$];
  logic [LINE_W-1:0] dc_exp_q[$];
  logic              dc_we_q[$];
  dc_cmd_t           pay_q[$];

  bit m_open = 1'b0;     // a transaction has been granted and not yet answered
  bit m_acc  = 1'b0;     // memory has accepted the open transaction
  bit m_own_dc = 1'b0;
  int m_cnt  = 0;        // cycles I$ has been requesting without being served

  int cyc = 0;
  int ic_hs_cnt = 0, dc_hs_cnt = 0, ic_rsp_cnt = 0, dc_rsp_cnt = 0, stall_cnt = 0;
  int ic_hs_cyc = 0, ic_hs_cyc_prev = 0, dc_hs_cyc = 0, ic_rsp_cyc = 0;
  logic [LINE_W-1:0] last_ic_data = '0, last_dc_data = '0;

  function automatic logic [LINE_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  initial begin
    bit win_ic, win_dc, exp_rsp;
    dc_cmd_t p;
    logic [LINE_W-1:0] e;
    logic e_we;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_open = 1'b0; m_acc = 1'b0; m_cnt = 0;
        ic_exp_q.delete(); dc_exp_q.delete(); dc_we_q.delete(); pay_q.delete();
        continue;
      end

      // Arbitration rule: free port, D$ first unless I$ has waited long enough.
      win_ic = !m_open && ic_req_valid &&
               (!dc_req_valid || (GUARD && m_cnt >= STARVE_LIMIT));
      win_dc = !m_open && dc_req_valid && !win_ic;
      check_bit("ic_req_ready", ic_req_ready, win_ic);
      check_bit("dc_req_ready", dc_req_ready, win_dc);
      check_bit("mem_req_valid", mem_req_valid, m_open && !m_acc);
      check_bit("state_idle", dbg_state == 2'd0, !m_open);
      exp_rsp = m_open && m_acc && mem_rsp_valid;
      check_bit("ic_rsp_valid", ic_rsp_valid, exp_rsp && !m_own_dc);
      check_bit("dc_rsp_valid", dc_rsp_valid, exp_rsp && m_own_dc);

      // Registered payload must match what was handed over, every REQ cycle.
      if (mem_req_valid) begin
        if (pay_q.size() == 0) begin
          fail_now("mem_req_payload", "request with no granted transaction");
        end else begin
          check_val("mem_req_addr", LINE_W'(mem_req_addr), LINE_W'(pay_q[0].addr));
          check_bit("mem_req_we", mem_req_we, pay_q[0].we);
          check_val("mem_req_wdata", mem_req_wdata, pay_q[0].wdata);
        end
        if (!mem_req_ready) stall_cnt++;
        if (mem_req_ready) begin
          if (pay_q.size() > 0) void'(pay_q.pop_front());
          acc_seen = 1'b1; acc_addr = mem_req_addr; acc_we = mem_req_we;
          acc_wdata = mem_req_wdata;
        end
      end

      // Scoreboard pops on any response the DUT presents.
      if (ic_rsp_valid) begin
        ic_rsp_cnt++; ic_rsp_cyc = cyc; last_ic_data = ic_rsp_data;
        if (ic_exp_q.size() == 0) fail_now("ic_rsp_data", "unexpected I$ response");
        else begin
          e = ic_exp_q.pop_front();
          check_val("ic_rsp_data", ic_rsp_data, e);
        end
      end
      if (dc_rsp_valid) begin
        dc_rsp_cnt++; last_dc_data = dc_rsp_data;
        if (dc_exp_q.size() == 0) fail_now("dc_rsp_data", "unexpected D$ response");
        else begin
          e = dc_exp_q.pop_front();
          e_we = dc_we_q.pop_front();
          if (!e_we) check_val("dc_rsp_data", dc_rsp_data, e);
        end
      end

      // Stimulus issued: push expected results at the handshake.
      if (win_ic && ic_req_valid) begin
        ic_exp_q.push_back(ref_read(ic_req_addr));
        p.addr = ic_req_addr; p.we = 1'b0; p.wdata = '0;
        pay_q.push_back(p);
      end
      if (win_dc && dc_req_valid) begin
        if (dc_req_we) ref_mem[dc_req_addr] = dc_req_wdata;
        dc_exp_q.push_back(dc_req_we ? '0 : ref_read(dc_req_addr));
        dc_we_q.push_back(dc_req_we);
        p.addr = dc_req_addr; p.we = dc_req_we; p.wdata = dc_req_wdata;
        pay_q.push_back(p);
      end

      if (ic_req_valid && ic_req_ready) begin
        ic_hs_seen = 1'b1; ic_hs_cnt++; ic_hs_cyc_prev = ic_hs_cyc; ic_hs_cyc = cyc;
      end
      if (dc_req_valid && dc_req_ready) begin
        dc_hs_seen = 1'b1; dc_hs_cnt++; dc_hs_cyc = cyc;
      end

      // Model advance.
      if (win_ic || win_dc) begin
        m_open = 1'b1; m_acc = 1'b0; m_own_dc = win_dc;
      end else if (m_open && !m_acc && mem_req_ready) begin
        m_acc = 1'b1;
      end else if (exp_rsp) begin
        m_open = 1'b0;
      end
      if (win_ic) m_cnt = 0;
      else if (ic_req_valid && m_cnt < STARVE_LIMIT) m_cnt++;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers for the directed sequence
  // ---------------------------------------------------------------------------
  task automatic wait_quiet(input int max_cycles, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (n < max_cycles &&
               (ic_cmd_q.size() != 0 || dc_cmd_q.size() != 0 || m_open ||
                ic_exp_q.size() != 0 || dc_exp_q.size() != 0));
    if (n >= max_cycles) fail_now(name, "timed out waiting for idle");
    repeat (2) @(negedge clk);
  endtask

  task automatic push_dc(input logic [ADDR_W-1:0] a, input logic we,
                         input logic [LINE_W-1:0] wd);
    dc_cmd_t c;
    c.addr = a; c.we = we; c.wdata = wd;
    dc_cmd_q.push_back(c);
  endtask

  // Hard stop in case something wedges beyond every per-wait bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int d0, r0, s0, n;
    logic [LINE_W-1:0] a5_line, wb_line;
    a5_line = {16{8'hA5}};
    wb_line = {4{32'h1234_5678}};
    env_mem[12'h010] = a5_line;
    ref_mem[12'h010] = a5_line;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_mem_req_valid", mem_req_valid, 1'b0);
    check_val("rst_mem_req_addr", LINE_W'(mem_req_addr), '0);
    check_bit("rst_mem_req_we", mem_req_we, 1'b0);
    check_val("rst_mem_req_wdata", mem_req_wdata, '0);
    check_val("rst_state", LINE_W'(dbg_state), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // I$ reads with immediate memory: 3-cycle turnaround, rsp at N+2.
    r0 = dc_rsp_cnt;
    ic_cmd_q.push_back(12'h011);
    ic_cmd_q.push_back(12'h010);
    wait_quiet(100, "ic_only");
    check_val("ic_latency", LINE_W'(ic_rsp_cyc - ic_hs_cyc), LINE_W'(2));
    check_val("ic_turnaround", LINE_W'(ic_hs_cyc - ic_hs_cyc_prev), LINE_W'(3));
    check_val("ic_a5_data", last_ic_data, a5_line);
    check_val("ic_only_no_dc_rsp", LINE_W'(dc_rsp_cnt - r0), '0);

    // D$ writeback with a 3-cycle memory stall, then read it back.
    s0 = stall_cnt; r0 = dc_rsp_cnt;
    env_stall_left = 3;
    push_dc(12'h020, 1'b1, wb_line);
    wait_quiet(100, "dc_wb");
    check_val("dc_wb_stall_cycles", LINE_W'(stall_cnt - s0), LINE_W'(3));
    check_val("dc_wb_ack_count", LINE_W'(dc_rsp_cnt - r0), LINE_W'(1));
    push_dc(12'h020, 1'b0, '0);
    wait_quiet(100, "dc_rd");
    check_val("dc_readback", last_dc_data, wb_line);

    // Simultaneous requests: D$ first, I$ at the next IDLE.
    ic_cmd_q.push_back(12'h030);
    push_dc(12'h031, 1'b0, '0);
    wait_quiet(100, "both");
    check_val("both_order", LINE_W'(ic_hs_cyc - dc_hs_cyc), LINE_W'(3));

    // Starvation: back-to-back D$ with I$ continuously requesting.
    d0 = dc_hs_cnt; s0 = ic_hs_cnt;
    for (int i = 0; i < 12; i++) push_dc(ADDR_W'(12'h100 + i), 1'b0, '0);
    ic_cmd_q.push_back(12'h0F0);
    n = 0;
    while (ic_hs_cnt == s0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 200) fail_now("starve_ic_grant", "I$ never granted");
    check_val("starve_dc_before_ic", LINE_W'(dc_hs_cnt - d0), GUARD ? LINE_W'(3) : LINE_W'(12));
    wait_quiet(300, "starve");

    // Stray responses in IDLE and in the accept cycle are ignored.
    env_stray_pct = 100;
    r0 = ic_rsp_cnt;
    repeat (5) @(negedge clk);
    ic_cmd_q.push_back(12'h040);
    wait_quiet(100, "stray");
    check_val("stray_ic_rsp_count", LINE_W'(ic_rsp_cnt - r0), LINE_W'(1));
    check_val("stray_ic_data", last_ic_data, init_line(12'h040));
    env_stray_pct = 0;

    // Randomized traffic.
    env_ready_pct = 60; env_delay_min = 0; env_delay_max = 3; env_stray_pct = 15;
    for (int b = 0; b < 40; b++) begin
      int ni, nd;
      ni = $urandom_range(3, 0);
      nd = $urandom_range(3, 0);
      for (int i = 0; i < ni; i++) ic_cmd_q.push_back(ADDR_W'($urandom_range(15, 0)));
      for (int i = 0; i < nd; i++)
        push_dc(ADDR_W'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), rnd_line());
      repeat ($urandom_range(15, 0)) @(negedge clk);
    end
    wait_quiet(5000, "random");

    // Reset while waiting for the response; the late response must vanish.
    env_ready_pct = 100; env_delay_min = 1; env_delay_max = 1; env_stray_pct = 0;
    ic_cmd_q.push_back(12'h050);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req_valid && mem_req_ready) && n < 50);
    if (n >= 50) fail_now("rst_mid_accept", "request never accepted");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_bit("rst_mid_ic_rsp", ic_rsp_valid, 1'b0);
    check_bit("rst_mid_dc_rsp", dc_rsp_valid, 1'b0);
    check_bit("rst_mid_mem_req_valid", mem_req_valid, 1'b0);
    check_val("rst_mid_state", LINE_W'(dbg_state), '0);
    repeat (3) @(negedge clk);
    check_val("rst_mid_state_hold", LINE_W'(dbg_state), '0);

    // Post-reset sanity: arbiter still serves requests.
    env_delay_min = 0; env_delay_max = 0;
    ic_cmd_q.push_back(12'h060);
    wait_quiet(100, "post_rst");

    check_val("ic_exp_drained", LINE_W'(ic_exp_q.size()), '0);
    check_val("dc_exp_drained", LINE_W'(dc_exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
